// File: rtl/mem_pkg.sv
// Shared definitions for the block-transfer DMA:
// default widths, op codes and FSM state encoding.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int STRIDE = 2;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Source/destination pointers and remaining word count.
// Pointers wrap modulo 2^ADDR_W.
module mem_addr_gen
    import mem_pkg::*;
#(
    parameter int AW  = ADDR_W,
    parameter int STP = STRIDE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] src_in,
    input  logic [AW-1:0] dst_in,
    input  logic [7:0]    len_in,
    output logic [AW-1:0] src,
    output logic [AW-1:0] dst,
    output logic          last
);

    localparam logic [AW-1:0] STEP = AW'(STP);

    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [7:0]    cnt_q, cnt_d;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load) begin
            src_d = src_in;
            dst_d = dst_in;
            cnt_d = len_in;
        end else if (step) begin
            src_d = src_q + STEP;
            dst_d = dst_q + STEP;
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign src  = src_q;
    assign dst  = dst_q;
    // The write being issued now is the final one.
    assign last = (cnt_q == 8'd1);

endmodule

// File: rtl/mem_dma.sv
// Block copy/fill initiator acting as master of the single-port
// word memory; copy alternates RD/WR, fill streams WR.
module mem_dma
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int STRIDE = mem_pkg::STRIDE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [7:0]        words_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        wdone_q, wdone_d;
    logic              abrt_q, abrt_d;

    logic              load;
    logic              step;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic              last;

    mem_addr_gen #(
        .AW  (ADDR_W),
        .STP (STRIDE)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .src_in (src_addr),
        .dst_in (dst_addr),
        .len_in (len),
        .src    (src),
        .dst    (dst),
        .last   (last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fill_d    = fill_q;
        data_d    = data_q;
        wdone_d   = wdone_q;
        abrt_d    = abrt_q;
        load      = 1'b0;
        step      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    wdone_d = '0;
                    abrt_d  = 1'b0;
                    if (len == 8'd0) begin
                        state_d = S_FIN;
                    end else begin
                        load    = 1'b1;
                        op_d    = op;
                        fill_d  = fill_data;
                        state_d = (op == OP_FILL) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                mem_addr = src;
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    mem_read = 1'b1;
                    data_d   = mem_rdata;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                mem_addr  = dst;
                mem_wdata = (op_q == OP_FILL) ? fill_q : data_q;
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    mem_write = 1'b1;
                    wdone_d   = wdone_q + 8'd1;
                    step      = 1'b1;
                    if (last) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = (op_q == OP_COPY) ? S_RD : S_WR;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_COPY;
            fill_q  <= '0;
            data_q  <= '0;
            wdone_q <= '0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            wdone_q <= wdone_d;
            abrt_q  <= abrt_d;
        end
    end

    assign busy       = (state_q == S_RD) || (state_q == S_WR);
    assign done       = (state_q == S_FIN);
    assign aborted    = done && abrt_q;
    assign words_done = wdone_q;

endmodule

// File: tb/tb_mem_dma.sv
// Randomised and directed checks of mem_dma against a word-level
// reference of the copy/fill rules and their cycle counts.
module tb_mem_dma;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [7:0]  src_addr = '0;
    logic [7:0]  dst_addr = '0;
    logic [7:0]  len = '0;
    logic [15:0] fill_data = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  words_done;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] mem [256];
    logic [15:0] refm [256];
    logic        preload = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_data  (fill_data),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory: address registered mid-cycle so the word is ready
    // by the edge that closes the read cycle.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h00] <= 16'h2BCD;
            mem[8'h04] <= 16'h1234;
            mem[8'h06] <= 16'hDEAD;
            mem[8'h08] <= 16'hBEEF;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== refm[i]) diffs++;
        end
        check(tag, diffs, 0);
    endtask

    task automatic run_xfer(input logic o, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] n,
                            input logic [15:0] f, input int ab,
                            input bit hold, input string tag);
        int total, nwr, exp_done, exp_busy, exp_rd;
        int busy_c, rd_c, wr_c, done_c;
        bit exp_ab, got_ab, both;
        logic [7:0] a_s, a_d;
        total = o ? int'(n) : 2 * int'(n);
        if (ab != 0 && ab <= total) begin
            nwr      = o ? ab - 1 : (ab - 1) / 2;
            exp_rd   = o ? 0 : ab / 2;
            exp_done = ab + 1;
            exp_busy = ab;
            exp_ab   = 1'b1;
        end else begin
            nwr      = n;
            exp_rd   = o ? 0 : int'(n);
            exp_done = total + 1;
            exp_busy = total;
            exp_ab   = 1'b0;
        end
        busy_c = 0; rd_c = 0; wr_c = 0; done_c = 0;
        got_ab = 1'b0; both = 1'b0;

        @(negedge clk);
        start = 1'b1; op = o; src_addr = s; dst_addr = d;
        len = n; fill_data = f;
        @(posedge clk); #1;
        if (hold) begin
            op = ~o; len = 8'd1; dst_addr = 8'h80;
            src_addr = 8'h82; fill_data = 16'hFFFF;
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c <= 600 && done_c == 0; c++) begin
            abort = (c == ab);
            @(negedge clk);
            if (busy) busy_c++;
            if (mem_read) rd_c++;
            if (mem_write) wr_c++;
            if (mem_read && mem_write) both = 1'b1;
            if (done) begin
                done_c = c;
                got_ab = aborted;
                start  = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;

        check({tag, ".done_cycle"}, done_c, exp_done);
        check({tag, ".busy_cycles"}, busy_c, exp_busy);
        check({tag, ".reads"}, rd_c, exp_rd);
        check({tag, ".writes"}, wr_c, nwr);
        check({tag, ".rd_wr_excl"}, both, 1'b0);
        check({tag, ".aborted"}, got_ab, exp_ab);
        @(negedge clk);
        check({tag, ".words_done"}, words_done, nwr);

        for (int i = 0; i < nwr; i++) begin
            a_s = s + 8'(2 * i);
            a_d = d + 8'(2 * i);
            refm[a_d] = o ? f : refm[a_s];
        end
        check_mem({tag, ".mem"});
    endtask

    initial begin
        logic [7:0] rs, rd, rn;
        int rab;
        for (int i = 0; i < 256; i++) refm[i] = 16'h0000;
        refm[8'h00] = 16'h2BCD;
        refm[8'h04] = 16'h1234;
        refm[8'h06] = 16'hDEAD;
        refm[8'h08] = 16'hBEEF;

        #1;
        check("reset_outputs",
              {busy, done, aborted, words_done, mem_read, mem_write,
               mem_addr, mem_wdata}, 37'd0);
        @(posedge clk); #1;
        preload = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_xfer(OP_COPY, 8'h04, 8'h10, 8'd3, 16'h0, 0, 0, "copy3");
        check("copy3.w10", mem[8'h10], 16'h1234);
        check("copy3.w14", mem[8'h14], 16'hBEEF);

        run_xfer(OP_FILL, 8'h00, 8'hFC, 8'd3, 16'hA5A5, 0, 0, "fill_wrap");
        check("fill_wrap.w00", mem[8'h00], 16'hA5A5);
        check("fill_wrap.w02", mem[8'h02], 16'h0000);

        run_xfer(OP_COPY, 8'h04, 8'h50, 8'd0, 16'h0, 0, 0, "len0");

        refm[8'h00] = 16'h2BCD;
        run_xfer(OP_FILL, 8'h00, 8'h00, 8'd1, 16'h2BCD, 0, 0, "restore");
        run_xfer(OP_COPY, 8'h00, 8'h20, 8'd4, 16'h0, 3, 0, "abort_rd2");
        check("abort_rd2.w20", mem[8'h20], 16'h2BCD);
        check("abort_rd2.w22", mem[8'h22], 16'h0000);

        run_xfer(OP_COPY, 8'h04, 8'h06, 8'd3, 16'h0, 0, 1, "overlap_hold");
        run_xfer(OP_FILL, 8'h00, 8'h60, 8'd4, 16'h5A5A, 3, 0, "abort_fill");

        // Fill interrupted by reset after three completed writes.
        @(negedge clk);
        start = 1'b1; op = OP_FILL; dst_addr = 8'h40;
        len = 8'd8; fill_data = 16'h7777;
        @(posedge clk); #1;
        len = 8'd2; op = OP_COPY; dst_addr = 8'h90;
        for (int c = 1; c <= 3; c++) begin
            start = (c != 2);
            @(negedge clk);
        end
        check("rst_mid.words_done", words_done, 8'd2);
        check("rst_mid.busy", busy, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("rst_mid.outputs",
              {busy, done, aborted, words_done, mem_read, mem_write,
               mem_addr, mem_wdata}, 37'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.idle", {busy, done}, 2'b00);
        for (int i = 0; i < 3; i++) refm[8'h40 + 8'(2 * i)] = 16'h7777;
        check_mem("rst_mid.mem");
        run_xfer(OP_FILL, 8'h00, 8'h30, 8'd1, 16'hC3C3, 0, 0, "post_rst");

        for (int t = 0; t < 25; t++) begin
            rs  = 8'($urandom) & 8'hFE;
            rd  = 8'($urandom) & 8'hFE;
            rn  = 8'($urandom_range(0, 10));
            rab = ($urandom_range(0, 2) == 0) ?
                  int'($urandom_range(1, 2 * int'(rn) + 2)) : 0;
            run_xfer(1'($urandom), rs, rd, rn, 16'($urandom), rab,
                     1'($urandom), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
